// File: rtl/sramb_stream_reader.sv
// sramb_stream_reader: streams LEN consecutive words out of a synchronous
// read-only RAM port onto a valid/ready stream, buffered by a small FIFO.
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   start, base, len   one-cycle transfer request with start address and count
//   busy, done         transfer in progress / one-cycle completion pulse
//   raddr, rdata       RAM read port (rdata valid one cycle after raddr)
//   odata, ovalid,
//   oready, olast      output stream; olast marks word number len
//   hswap              (only with SRAMB_READER_HSWAP_EN) swap data halves
//
// Optional feature macro: SRAMB_READER_HSWAP_EN adds the hswap input,
// sampled with start, which exchanges the high and low halves of every
// word of that transfer on odata.
module sramb_stream_reader #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   len,
`ifdef SRAMB_READER_HSWAP_EN
  input  logic                  hswap,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  ovalid,
  input  logic                  oready,
  output logic                  olast
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned HALF  = DATA_WIDTH / 2;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                 state;
  logic [LEN_W-1:0]       rd_left;   // reads still to issue
  logic [LEN_W-1:0]       out_left;  // words still to hand out
  logic                   inflight;  // a read was issued last cycle
  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   swap;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic [DATA_WIDTH-1:0]  head;

  // Issue only when the buffered plus in-flight words still fit the FIFO.
  assign issue = (state == FETCH) && (rd_left != '0) &&
                 ((OCC_W'(count) + OCC_W'(inflight)) < OCC_W'(FIFO_DEPTH));
  assign push   = inflight;
  assign ovalid = (count != '0);
  assign pop    = ovalid && oready;
  assign head   = mem[rd_ptr];
  assign olast  = ovalid && (out_left == LEN_W'(1));
  // Gating with ovalid keeps odata at zero whenever nothing is presented.
  assign odata  = !ovalid ? '0 :
                  swap    ? {head[HALF-1:0], head[DATA_WIDTH-1:HALF]} : head;

`ifdef SRAMB_READER_HSWAP_EN
  // Swap selection is captured per transfer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      swap <= 1'b0;
    end else if (state == IDLE && start) begin
      swap <= hswap;
    end
  end
`else
  assign swap = 1'b0;
`endif

  // FIFO storage; the RAM word arrives the cycle after its read was issued.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rdata;
    end
  end

  // Control FSM, read issue, FIFO pointers and status outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      raddr    <= '0;
      rd_left  <= '0;
      out_left <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        raddr   <= raddr + ADDR_WIDTH'(1);
        rd_left <= rd_left - LEN_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        out_left <= out_left - LEN_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      case (state)
        IDLE: begin
          if (start) begin
            raddr    <= base;
            rd_left  <= len;
            out_left <= len;
            if (len != '0) begin
              state <= FETCH;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (issue && rd_left == LEN_W'(1)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && olast) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sramb_stream_reader.sv
// Scoreboard bench for sramb_stream_reader: stimulus pushes the expected
// {olast, odata} words, a negedge monitor checks every presented word.
module tb_sramb_stream_reader;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [5:0] base;
  logic [6:0] len;
  logic       busy;
  logic       done;
  logic [5:0] raddr;
  logic [7:0] rdata;
  logic [7:0] odata;
  logic       ovalid;
  logic       oready;
  logic       olast;
`ifdef SRAMB_READER_HSWAP_EN
  logic       hswap;
`endif

  sramb_stream_reader #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base(base), .len(len),
`ifdef SRAMB_READER_HSWAP_EN
    .hswap(hswap),
`endif
    .busy(busy), .done(done), .raddr(raddr), .rdata(rdata),
    .odata(odata), .ovalid(ovalid), .oready(oready), .olast(olast)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model.
  logic [7:0] ram [64];
  always @(posedge clk) rdata <= ram[raddr];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc_cyc = -100;
  logic [8:0] sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every presented word; retire it when it is accepted.
  always @(negedge clk) begin
    if (rstn && ovalid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word: got %0h/%0b expected none", odata, olast);
      end else begin
        if ({olast, odata} !== sb[0]) begin
          n_err++;
          $display("FAIL stream_word: got last=%0b data=%0h expected last=%0b data=%0h",
                   olast, odata, sb[0][8], sb[0][7:0]);
        end
        if (oready) begin
          void'(sb.pop_front());
          if (olast) last_acc_cyc = cyc;
        end
      end
    end
  end

  task automatic issue_start(input logic [5:0] b, input logic [6:0] l);
    start = 1'b1; base = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic expect_word(input logic [7:0] d, input logic last);
    sb.push_back({last, d});
  endtask

  // Run until done, driving oready from a 4-cycle pattern; optionally pulse
  // a start while busy, which must be ignored.
  task automatic run_until_done(input logic [3:0] pat, input bit inject, input int maxc);
    int k = 0;
    bit got = 0;
    while (k < maxc && !got) begin
      @(posedge clk); #1;
      if (done) begin
        got = 1;
        chk("done_after_last", cyc, last_acc_cyc + 1);
        chk("busy_at_done", busy, 0);
      end else begin
        oready = pat[k % 4];
        if (inject) begin
          if (k == 3) begin
            start = 1'b1; base = 6'd40; len = 7'd2;
          end else begin
            start = 1'b0;
          end
        end
        k++;
      end
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_state", {busy, done, ovalid}, 3'b000);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 8'(i) + 8'h10;
    rstn = 1'b0; start = 1'b0; base = '0; len = '0; oready = 1'b0;
`ifdef SRAMB_READER_HSWAP_EN
    hswap = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {busy, done, ovalid, olast}, 4'b0000);
    chk("rst_raddr", raddr, 0);
    chk("rst_odata", odata, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // BASE=2 LEN=4, full throughput and latency.
    oready = 1'b1;
    expect_word(8'h12, 0); expect_word(8'h13, 0);
    expect_word(8'h14, 0); expect_word(8'h15, 1);
    issue_start(6'd2, 7'd4);
    chk("t1_busy", busy, 1);
    chk("t1_ovalid_n0", ovalid, 0);
    @(posedge clk); #1;
    chk("t1_ovalid_n1", ovalid, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("t1_ovalid_run", ovalid, 1);
      chk("t1_olast", olast, (k == 3) ? 1 : 0);
    end
    @(posedge clk); #1;
    chk("t1_done", done, 1);
    chk("t1_busy_fall", busy, 0);
    chk("t1_ovalid_end", ovalid, 0);
    @(posedge clk); #1;
    chk("t1_done_pulse", done, 0);

    // Address wrap: BASE=62 LEN=4.
    expect_word(8'h4E, 0); expect_word(8'h4F, 0);
    expect_word(8'h10, 0); expect_word(8'h11, 1);
    issue_start(6'd62, 7'd4);
    chk("t2_raddr0", raddr, 62);
    @(posedge clk); #1; chk("t2_raddr1", raddr, 63);
    @(posedge clk); #1; chk("t2_raddr2", raddr, 0);
    @(posedge clk); #1; chk("t2_raddr3", raddr, 1);
    run_until_done(4'b1111, 0, 40);

    // LEN=8 with oready 1,0,0,1 and a start while busy.
    for (int i = 0; i < 8; i++) expect_word(8'h10 + 8'(i), (i == 7));
    oready = 1'b1;
    issue_start(6'd0, 7'd8);
    run_until_done(4'b1001, 1, 100);
    idle_check(6);

    // LEN=0: done next cycle, nothing streamed, busy stays low.
    issue_start(6'd5, 7'd0);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_ovalid", ovalid, 0);
    idle_check(3);

    // Reset while the third word of LEN=8 is presented.
    oready = 1'b1;
    for (int i = 0; i < 8; i++) expect_word(8'h10 + 8'(i), (i == 7));
    issue_start(6'd0, 7'd8);
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        if (ovalid && odata == 8'h12) seen = 1;
        else begin @(posedge clk); #1; end
      end
      chk("t5_third_word_seen", seen, 1);
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("t5_rst_flags", {busy, done, ovalid, olast}, 4'b0000);
    chk("t5_rst_raddr", raddr, 0);
    sb.delete();
    rstn = 1'b1;
    expect_word(8'h10, 1);
    issue_start(6'd0, 7'd1);
    chk("t5_restart_busy", busy, 1);
    run_until_done(4'b1111, 0, 20);
    idle_check(2);

`ifdef SRAMB_READER_HSWAP_EN
    // Half swap: A5 -> 5A, 16 -> 61; start while busy ignored.
    ram[5] = 8'hA5;
    hswap = 1'b1;
    expect_word(8'h5A, 0); expect_word(8'h61, 1);
    issue_start(6'd5, 7'd2);
    hswap = 1'b0;
    run_until_done(4'b1001, 1, 40);
    idle_check(4);
`endif

    chk("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
